// File: rtl/branch_predictor_pkg.sv
// Shared encodings and constants for the fetch-side branch predictor.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t        CTR_INIT  = WNT;
  localparam ctr_t        CTR_ALLOC = WT;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function (combinational only).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      case (ctr_in)
        SNT:     ctr_out = WNT;
        WNT:     ctr_out = WT;
        default: ctr_out = ST;
      endcase
    end else begin
      case (ctr_in)
        ST:      ctr_out = WT;
        WT:      ctr_out = WNT;
        default: ctr_out = SNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, trained from execute.
// Optional BP_STATS_EN adds branch / mispredict event counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned TAG_BITS = 30 - IDX_BITS;
  localparam int unsigned ENTRIES  = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  ctr_t                ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_BITS-1:0] if_tag, upd_tag;
  logic                if_hit, upd_hit, mis_now;
  ctr_t                ctr_next;
  logic                unused_pc_lsbs;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign if_tag  = if_pc[31:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[31:IDX_BITS+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mis_now = upd_valid && (upd_taken != upd_pred_taken);

  sat_counter2 u_sat_counter2 (
    .ctr_in  (ctr_q[upd_idx]),
    .taken   (upd_taken),
    .ctr_out (ctr_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= '0;
      tag_q      <= '{default: '0};
      target_q   <= '{default: '0};
      ctr_q      <= '{default: CTR_INIT};
      mispredict <= 1'b0;
    end else begin
      mispredict <= mis_now;
      if (upd_valid) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= ctr_next;
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          ctr_q[upd_idx]    <= CTR_ALLOC;
        end
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid) stat_branches <= stat_branches + 32'd1;
      if (mis_now)   stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (also covers BP_STATS_EN when defined).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .mispredict     (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One update cycle; upd_valid drops right after the capturing edge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pt);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = pt;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    check({tag, "_target"}, pred_target, exp_tgt);
  endtask

  initial begin
    rstn = 1'b0; if_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    #3;
    look("reset_lookup", 32'h40, 1'b0, 32'h44);
    check("reset_mispredict", {31'd0, mispredict}, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    look("untrained", 32'h40, 1'b0, 32'h44);

    // First taken allocates at WT; same-cycle lookup still sees the old miss.
    if_pc = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100; upd_pred_taken = 1'b0;
    #1;
    check("samecyc_alloc_old", {31'd0, pred_taken}, 32'd0);
    tick();
    upd_valid = 1'b0;
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    look("alloc", 32'h40, 1'b1, 32'h100);
    tick();
    check("mispredict_clears", {31'd0, mispredict}, 32'd0);

    // Saturate up, then walk down to SNT and back.
    upd(32'h40, 1'b1, 32'h104, 1'b1);
    look("taken_tgt_update", 32'h40, 1'b1, 32'h104);
    upd(32'h40, 1'b1, 32'h104, 1'b1);
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    check("no_mispredict", {31'd0, mispredict}, 32'd0);
    look("sat_st", 32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'hDEAD, 1'b1);
    check("nt_mispredict", {31'd0, mispredict}, 32'd1);
    look("st_to_wt", 32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'hBEEF, 1'b1);
    look("wt_to_wnt", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("snt_to_wnt", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("wnt_to_wt", 32'h40, 1'b1, 32'h100);

    // Aliasing on index 0, and a not-taken miss must not allocate.
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look("alias_evicted", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 32'h200);
    upd(32'h1000, 1'b0, 32'h300, 1'b0);
    look("nt_noalloc", 32'h1000, 1'b0, 32'h1004);
    look("nt_noalloc_keep", 32'h83, 1'b1, 32'h200);

    // Same-cycle update to a hit entry: old prediction now, new one next cycle.
    if_pc = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b1;
    #1;
    check("samecyc_old", {31'd0, pred_taken}, 32'd1);
    tick();
    upd_valid = 1'b0;
    look("samecyc_new", 32'h80, 1'b0, 32'h84);

    look("pc_wrap", 32'hFFFFFFFC, 1'b0, 32'h0);

    // Async reset between edges.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("pre_async", 32'h40, 1'b1, 32'h100);
    rstn = 1'b0;
    #1;
    check("async_taken", {31'd0, pred_taken}, 32'd0);
    check("async_mispredict", {31'd0, mispredict}, 32'd0);
    #3;
    rstn = 1'b1;
    tick();
    look("post_async", 32'h40, 1'b0, 32'h44);

`ifdef BP_STATS_EN
    check("stats_br_nonzero", stat_branches, 32'd0);
    check("stats_mis_nonzero", stat_mispredicts, 32'd0);
    upd(32'h10, 1'b1, 32'h400, 1'b0);
    upd(32'h10, 1'b1, 32'h400, 1'b1);
    upd(32'h10, 1'b0, 32'h0,   1'b1);
    upd(32'h20, 1'b0, 32'h0,   1'b0);
    upd(32'h10, 1'b1, 32'h400, 1'b1);
    tick();
    check("stat_branches", stat_branches, 32'd5);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
    rstn = 1'b0;
    #1;
    check("stat_br_reset", stat_branches, 32'd0);
    check("stat_mis_reset", stat_mispredicts, 32'd0);
    rstn = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
